// File: rtl/seg_pkg.sv
// Shared constants, frame type and segment decoder for the 7-segment scan controller.
package seg_pkg;

  localparam int unsigned SEG_DIGITS = 8;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned IDX_W      = $clog2(SEG_DIGITS);

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;

  // One nibble per digit, digit 0 in the low nibble
  typedef logic [SEG_DIGITS-1:0][NIB_W-1:0] frame_t;

  localparam frame_t FRAME_DASHES = frame_t'(32'hAAAA_AAAA);

  // Nibble to active-low segments {g,f,e,d,c,b,a}; A renders as a dash
  function automatic logic [SEG_W-1:0] seg_decode(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = SEG_DASH;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot counter and digit index for the scan; flags the last cycle of each frame.
module seg_scan_timer
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned SLOT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [SLOT_W-1:0] slot,
  output logic [IDX_W-1:0]  idx,
  output logic              boundary_c,
  output logic              frame_tick
);

  logic slot_last_c;

  assign slot_last_c = (slot == SLOT_W'(SCAN_DIV - 1));
  assign boundary_c  = slot_last_c && (idx == IDX_W'(SEG_DIGITS - 1));

  // Advance slot each cycle, step digit index on slot wrap (index wraps 7->0 naturally)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot       <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary_c;
      if (slot_last_c) begin
        slot <= '0;
        idx  <= idx + IDX_W'(1);
      end else begin
        slot <= slot + SLOT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit 7-segment scan controller with tear-free frame updates.
// Optional blinking is compiled in with SEG_SCAN_BLINK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEAD_CYC     = 2,
  parameter int unsigned BLINK_FRAMES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [31:0]           upd_data,
`ifdef SEG_SCAN_BLINK_EN
  input  logic [SEG_DIGITS-1:0] blink_mask,
`endif
  output logic [SEG_DIGITS-1:0] dig_en_n,
  output logic [SEG_W-1:0]      seg_n,
  output logic                  frame_tick
);

  localparam int unsigned SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SLOT_W-1:0]     slot;
  logic [IDX_W-1:0]      idx;
  logic                  boundary_c;
  frame_t                staging;
  frame_t                active;
  logic                  blank_c;
  logic [SEG_DIGITS-1:0] dig_c;

  seg_scan_timer #(
    .SCAN_DIV (SCAN_DIV),
    .SLOT_W   (SLOT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot       (slot),
    .idx        (idx),
    .boundary_c (boundary_c),
    .frame_tick (frame_tick)
  );

  // Staging/active frame: accept when free, commit only at the frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_ready <= 1'b1;
      staging   <= '0;
      active    <= FRAME_DASHES;
    end else if (boundary_c && !upd_ready) begin
      active    <= staging;
      upd_ready <= 1'b1;
    end else if (upd_valid && upd_ready) begin
      staging   <= frame_t'(upd_data);
      upd_ready <= 1'b0;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  // Blink phase flips after every BLINK_FRAMES frame boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (boundary_c) begin
      if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  assign blank_c = blink_phase & blink_mask[idx];
`else
  logic unused_blink_cfg;

  assign unused_blink_cfg = ^32'(BLINK_FRAMES);
  assign blank_c          = 1'b0;
`endif

  // Digit enable: dark during dead time or when blinked off, else select current digit
  always_comb begin
    dig_c = '1;
    if ((slot >= SLOT_W'(DEAD_CYC)) && !blank_c) begin
      dig_c[idx] = 1'b0;
    end
  end

  // Output registers, one cycle behind the counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_en_n <= '1;
      seg_n    <= SEG_BLANK;
    end else begin
      dig_en_n <= dig_c;
      seg_n    <= seg_decode(active[idx]);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=4, DEAD_CYC=1, BLINK_FRAMES=2.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_data;
  logic [7:0]  blink_mask;
  logic [7:0]  dig_en_n;
  logic [6:0]  seg_n;
  logic        frame_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  seg_scan_ctrl #(
    .SCAN_DIV     (4),
    .DEAD_CYC     (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_data   (upd_data),
`ifdef SEG_SCAN_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .dig_en_n   (dig_en_n),
    .seg_n      (seg_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Outputs seen after tick belong to frame position (cyc-1)%32
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int tgt);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (((cyc - 1) % 32 != tgt) && (n < 100));
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_to: position %0d not reached, at %0d", tgt, (cyc - 1) % 32);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; upd_valid = 1'b0; upd_data = 32'h0; blink_mask = 8'h00;
    repeat (3) tick();
    n_cmp++; if (dig_en_n !== 8'hFF) begin n_bad++; $display("FAIL reset_dig: got %h exp ff", dig_en_n); end
    n_cmp++; if (seg_n !== 7'h7F) begin n_bad++; $display("FAIL reset_seg: got %h exp 7f", seg_n); end
    n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b exp 1", upd_ready); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b exp 0", frame_tick); end
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_idle_scan();
    int p;
    logic [7:0] e;
    for (int n = 0; n < 64; n++) begin
      tick();
      p = (cyc - 1) % 32;
      e = 8'h01 << (p / 4);
      e = (p % 4 == 0) ? 8'hFF : ~e;
      n_cmp++; if (dig_en_n !== e) begin n_bad++; $display("FAIL idle_dig p%0d: got %h exp %h", p, dig_en_n, e); end
      n_cmp++; if (seg_n !== 7'h3F) begin n_bad++; $display("FAIL idle_seg p%0d: got %h exp 3f", p, seg_n); end
      n_cmp++; if (frame_tick !== (p == 31)) begin n_bad++; $display("FAIL idle_tick p%0d: got %b exp %b", p, frame_tick, p == 31); end
    end
  endtask

  task automatic test_update();
    run_to(9);
    upd_valid = 1'b1; upd_data = 32'h7654_3210;
    tick();
    upd_valid = 1'b0; upd_data = 32'hDEAD_BEEF;
    n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL upd_ready_drop: got %b exp 0", upd_ready); end
    run_to(30);
    n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL upd_ready_pend: got %b exp 0", upd_ready); end
    n_cmp++; if (seg_n !== 7'h3F) begin n_bad++; $display("FAIL upd_old_frame: got %h exp 3f", seg_n); end
    tick();
    n_cmp++; if (frame_tick !== 1'b1) begin n_bad++; $display("FAIL upd_tick: got %b exp 1", frame_tick); end
    n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL upd_ready_back: got %b exp 1", upd_ready); end
    run_to(1);
    n_cmp++; if (dig_en_n !== 8'hFE) begin n_bad++; $display("FAIL upd_d0_dig: got %h exp fe", dig_en_n); end
    n_cmp++; if (seg_n !== 7'h40) begin n_bad++; $display("FAIL upd_d0_seg: got %h exp 40", seg_n); end
    run_to(13);
    n_cmp++; if (dig_en_n !== 8'hF7) begin n_bad++; $display("FAIL upd_d3_dig: got %h exp f7", dig_en_n); end
    n_cmp++; if (seg_n !== 7'h30) begin n_bad++; $display("FAIL upd_d3_seg: got %h exp 30", seg_n); end
  endtask

  task automatic test_hold_valid();
    upd_valid = 1'b1; upd_data = 32'h1111_1111;
    tick();
    upd_data = 32'h89AB_CDEF;
    tick();
    n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready: got %b exp 0", upd_ready); end
    run_to(30);
    n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready_late: got %b exp 0", upd_ready); end
    n_cmp++; if (seg_n !== 7'h78) begin n_bad++; $display("FAIL hold_d7_prev: got %h exp 78", seg_n); end
    tick();
    n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL hold_ready_commit: got %b exp 1", upd_ready); end
    run_to(1);
    upd_valid = 1'b0;
    n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL hold_accept2: got %b exp 0", upd_ready); end
    n_cmp++; if (seg_n !== 7'h79) begin n_bad++; $display("FAIL hold_a_d0: got %h exp 79", seg_n); end
    run_to(17);
    n_cmp++; if (seg_n !== 7'h79) begin n_bad++; $display("FAIL hold_a_d4: got %h exp 79", seg_n); end
    run_to(31);
    n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL hold_ready2: got %b exp 1", upd_ready); end
    run_to(1);
    n_cmp++; if (seg_n !== 7'h0E) begin n_bad++; $display("FAIL hold_b_d0: got %h exp 0e", seg_n); end
    run_to(29);
    n_cmp++; if (dig_en_n !== 8'h7F) begin n_bad++; $display("FAIL hold_b_d7_dig: got %h exp 7f", dig_en_n); end
    n_cmp++; if (seg_n !== 7'h00) begin n_bad++; $display("FAIL hold_b_d7_seg: got %h exp 00", seg_n); end
  endtask

  task automatic test_boundary_xfer();
    run_to(30);
    n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL bnd_ready: got %b exp 1", upd_ready); end
    upd_valid = 1'b1; upd_data = 32'h2222_2222;
    tick();
    upd_valid = 1'b0;
    n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL bnd_accept: got %b exp 0", upd_ready); end
    n_cmp++; if (frame_tick !== 1'b1) begin n_bad++; $display("FAIL bnd_tick: got %b exp 1", frame_tick); end
    run_to(1);
    n_cmp++; if (seg_n !== 7'h0E) begin n_bad++; $display("FAIL bnd_still_old: got %h exp 0e", seg_n); end
    run_to(30);
    n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL bnd_pending: got %b exp 0", upd_ready); end
    tick();
    n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL bnd_commit: got %b exp 1", upd_ready); end
    run_to(1);
    n_cmp++; if (seg_n !== 7'h24) begin n_bad++; $display("FAIL bnd_new: got %h exp 24", seg_n); end
  endtask

  task automatic test_reset_midframe();
    int p;
    logic [7:0] e;
    run_to(5);
    upd_valid = 1'b1; upd_data = 32'h3333_3333;
    tick();
    upd_valid = 1'b0;
    n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_pend: got %b exp 0", upd_ready); end
    n_cmp++; if (dig_en_n !== 8'hFD) begin n_bad++; $display("FAIL rst_pre_dig: got %h exp fd", dig_en_n); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (dig_en_n !== 8'hFF) begin n_bad++; $display("FAIL rst_dig: got %h exp ff", dig_en_n); end
    n_cmp++; if (seg_n !== 7'h7F) begin n_bad++; $display("FAIL rst_seg: got %h exp 7f", seg_n); end
    n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b exp 1", upd_ready); end
    repeat (2) tick();
    rst_n = 1'b1;
    cyc = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      p = (cyc - 1) % 32;
      e = 8'h01 << (p / 4);
      e = (p % 4 == 0) ? 8'hFF : ~e;
      n_cmp++; if (dig_en_n !== e) begin n_bad++; $display("FAIL rst_scan_dig p%0d: got %h exp %h", p, dig_en_n, e); end
      n_cmp++; if (seg_n !== 7'h3F) begin n_bad++; $display("FAIL rst_scan_seg p%0d: got %h exp 3f", p, seg_n); end
      n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_scan_ready p%0d: got %b exp 1", p, upd_ready); end
    end
  endtask

`ifdef SEG_SCAN_BLINK_EN
  task automatic test_blink();
    int f;
    logic [7:0] e;
    rst_n = 1'b0;
    blink_mask = 8'h01;
    tick();
    rst_n = 1'b1;
    cyc = 0;
    for (int n = 0; n < 5; n++) begin
      run_to(1);
      f = (cyc - 1) / 32;
      e = (f == 2 || f == 3) ? 8'hFF : 8'hFE;
      n_cmp++; if (dig_en_n !== e) begin n_bad++; $display("FAIL blink_d0 f%0d: got %h exp %h", f, dig_en_n, e); end
      run_to(5);
      n_cmp++; if (dig_en_n !== 8'hFD) begin n_bad++; $display("FAIL blink_d1 f%0d: got %h exp fd", f, dig_en_n); end
      n_cmp++; if (seg_n !== 7'h3F) begin n_bad++; $display("FAIL blink_seg f%0d: got %h exp 3f", f, seg_n); end
    end
    blink_mask = 8'h00;
  endtask
`endif

  initial begin
    test_reset();
    test_idle_scan();
    test_update();
    test_hold_valid();
    test_boundary_xfer();
    test_reset_midframe();
`ifdef SEG_SCAN_BLINK_EN
    test_blink();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
